// File: rtl/data_mem_bytelane.sv
// Byte-lane data memory for MIPS loads/stores: per-lane RAM writes, registered
// sign/zero-extended reads, alignment/range flags and an error-free access counter.
module data_mem_bytelane #(
    parameter int          DEPTH = 512,
    parameter logic [31:0] BASE  = 32'h0000_0000,
    parameter int          CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req,
    input  logic             i_we,
    input  logic [31:0]      i_a,
    input  logic [31:0]      i_wd,
    input  logic [1:0]       i_size,
    input  logic             i_uns,
    output logic [31:0]      o_rd,
    output logic             o_rvalid,
    output logic             o_misalign,
    output logic             o_oor,
    output logic [CNT_W-1:0] o_acc_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_oor_hi;
    logic          w_oor;
    logic          w_mis;
    logic          w_err;
    logic          w_wr;
    logic          w_rd_en;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    logic             r_rvalid;
    logic             r_misalign;
    logic             r_oor;
    logic [CNT_W-1:0] r_acc_cnt;
    logic             r_zero;
    logic [1:0]       r_lane;
    logic [1:0]       r_size;
    logic             r_uns;

    // BASE is word-aligned, so the low offset bits are the byte lane.
    assign w_off = i_a - BASE;
    assign w_idx = w_off[AW+1:2];

    generate
        if (AW + 2 < 32) begin : g_oor_hi
            assign w_oor_hi = |w_off[31:AW+2];
        end else begin : g_oor_full
            assign w_oor_hi = 1'b0;
        end
    endgenerate

    assign w_oor   = w_oor_hi | (i_a < BASE);
    assign w_err   = w_mis | w_oor;
    assign w_wr    = i_req & i_we & ~w_err;
    assign w_rd_en = i_req & ~i_we & ~w_err;

    always_comb begin
        w_mis   = 1'b0;
        w_be    = 4'b0000;
        w_wdata = i_wd;
        case (i_size)
            2'b00: begin
                w_be    = 4'b0001 << w_off[1:0];
                w_wdata = {4{i_wd[7:0]}};
            end
            2'b01: begin
                w_mis   = w_off[0];
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_wd[15:0]}};
            end
            2'b10: begin
                w_mis = |w_off[1:0];
                w_be  = 4'b1111;
            end
            default: w_mis = 1'b1;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_q;

            always_ff @(posedge i_clk) begin
                if (w_wr && w_be[gi]) begin
                    r_mem[w_idx] <= w_wdata[8*gi +: 8];
                end
                if (w_rd_en) begin
                    r_q <= r_mem[w_idx];
                end
            end

            assign w_word[8*gi +: 8] = r_q;
        end
    endgenerate

    // r_zero forces RD to 0 after reset or an erroring load, leaving the RAM read register unreset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rvalid   <= 1'b0;
            r_misalign <= 1'b0;
            r_oor      <= 1'b0;
            r_acc_cnt  <= '0;
            r_zero     <= 1'b1;
            r_lane     <= 2'b00;
            r_size     <= 2'b10;
            r_uns      <= 1'b0;
        end else begin
            r_rvalid   <= i_req & ~i_we;
            r_misalign <= i_req & w_mis;
            r_oor      <= i_req & w_oor;
            if (w_wr || w_rd_en) begin
                r_acc_cnt <= r_acc_cnt + CNT_ONE;
            end
            if (w_rd_en) begin
                r_zero <= 1'b0;
                r_lane <= w_off[1:0];
                r_size <= i_size;
                r_uns  <= i_uns;
            end else if (i_req && !i_we) begin
                r_zero <= 1'b1;
            end
        end
    end

    assign w_byte = w_word[{r_lane, 3'b000} +: 8];
    assign w_half = r_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        o_rd = 32'h0;
        if (!r_zero) begin
            case (r_size)
                2'b00:   o_rd = r_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
                2'b01:   o_rd = r_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                default: o_rd = w_word;
            endcase
        end
    end

    assign o_rvalid   = r_rvalid;
    assign o_misalign = r_misalign;
    assign o_oor      = r_oor;
    assign o_acc_cnt  = r_acc_cnt;
endmodule

// File: doc/data_mem_bytelane.md
Name: data_mem_bytelane

Overview:
- Parametrised successor to the word-only data memory in the MCU datapath.
- Single-port synchronous RAM serving MIPS lb/lbu/lh/lhu/lw/sb/sh/sw.
- Adds byte-lane writes, sign/zero-extended sub-word reads, a registered read port with a valid strobe, alignment and range checking, and an access counter for debug probes.
- Sits between the ALU result/rt-data path and the writeback mux.

Parameters:
DEPTH, 512, number of 32-bit words; power of two, minimum 2.
AW, $clog2(DEPTH), word-index width, derived (localparam).
BASE, 32'h0000_0000, byte address of word 0; word-aligned.
CNT_W, 32, width of access counter.

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
REQ  input  1  access request this cycle
WE  input  1  1 = store, 0 = load; ignored when REQ=0
A  input  32  MIPS byte address
WD  input  32  store data, right-justified (byte in [7:0], half in [15:0])
SIZE  input  2  00 byte, 01 half, 10 word, 11 illegal
UNS  input  1  1 = zero-extend loads (lbu/lhu), 0 = sign-extend
RD  output  32  load data, extended to 32 bits
RVALID  output  1  RD holds the result of a load accepted last cycle
MISALIGN  output  1  last-cycle request was misaligned or used SIZE=11
OOR  output  1  last-cycle request fell outside [BASE, BASE+4*DEPTH)
ACC_CNT  output  CNT_W  count of completed, error-free accesses

Behaviour:
- Reset (RST_N=0, asynchronous): RD=0, RVALID=0, MISALIGN=0, OOR=0, ACC_CNT=0. Array contents are not reset. Deassertion is taken synchronously by the bench; no request during the reset cycle.
- Index: off = A-BASE; idx = off[AW+1:2].
- Range check: OOR condition is off[31:AW+2] != 0, or A < BASE.
- Alignment check: MISALIGN condition is (SIZE=01 and A[0]) or (SIZE=10 and A[1:0]!=0) or SIZE=11.
- Error priority: MISALIGN is evaluated first. If MISALIGN, OOR is still reported independently; both may be 1.
- Store (REQ=1, WE=1, no error): array updated at the accepting edge with per-lane enables.
  - Byte: lane A[1:0] <= WD[7:0].
  - Half: lanes {A[1],1},{A[1],0} <= WD[15:0].
  - Word: all lanes <= WD.
  - Lanes not enabled are unchanged.
- Load (REQ=1, WE=0, no error): word read at the accepting edge. The byte/half is selected by A[1:0] (latched) and extended per UNS. RD and RVALID=1 appear one cycle later (latency 1).
- Store-then-load to the same word in consecutive cycles returns the newly written value; the array is written before the next read, so no forwarding logic is needed.
- Error on any request: array not written. One cycle later MISALIGN/OOR pulse for exactly one cycle. A load with an error gives RVALID=1 and RD=0; a store with an error gives RVALID=0.
- Stores give RVALID=0 the following cycle; RD holds its previous value.
- REQ=0: RVALID=0 and flags 0 the next cycle; RD holds.
- ACC_CNT increments by 1 one cycle after each error-free accepted load or store and wraps at 2^CNT_W to 0.
- Back-to-back requests are accepted every cycle; there is no stall and no ready signal.
- Reset mid-operation: the pending load result is discarded (RVALID=0). A store on the edge coinciding with reset assertion is not guaranteed.
- Storage is a reg array inferred as distributed or block RAM; no IP-core dependency.

Test Plan:
- sw 0xDEADBEEF @0x10, then lw @0x10 next cycle -> RD=0xDEADBEEF, RVALID=1 one cycle after the lw; ACC_CNT=2.
- sb 0x7F @0x11 over 0xDEADBEEF, then lw @0x10 -> 0xDEAD7FEF. Then lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE.
- sh 0x8001 @0x22, then lh @0x22 -> 0xFFFF8001; lhu -> 0x00008001; lw @0x20 -> upper half 0x8001, lower half unchanged from its prior value.
- lw @0x12, sh @0x21, SIZE=11 @0x0 -> MISALIGN=1 for one cycle each. The lw gives RVALID=1 with RD=0. Memory unchanged (verify by readback). ACC_CNT not incremented.
- With DEPTH=512: sw @0x800 -> OOR=1, no wrap-around write (word 0 unchanged). lw @0x7FC -> valid data, OOR=0.
- Preload ACC_CNT to 0xFFFFFFFF via 2^32-1 accesses or force, then one access -> wraps to 0. Assert RST_N=0 during a pending lw -> RVALID=0 and RD=0 immediately, asynchronously.
